// File: rtl/ifetch_pkg.sv
// ifetch_pkg: shared definitions for the instruction fetch stage.
//   state_e     - fetch FSM states (IDLE, REQ, WAIT, HOLD, FAULT)
//   INS_NOP     - instruction presented before the first fetch (addi x0,x0,0)
//   PC_INC      - sequential PC step
//   align_word  - clears the byte-offset bits of an address
package ifetch_pkg;

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        REQ   = 3'd1,
        WAIT  = 3'd2,
        HOLD  = 3'd3,
        FAULT = 3'd4
    } state_e;

    localparam logic [31:0] INS_NOP = 32'h0000_0013;
    localparam logic [31:0] PC_INC  = 32'd4;

    function automatic logic [31:0] align_word(input logic [31:0] addr);
        return addr & 32'hFFFF_FFFC;
    endfunction

endpackage

// File: rtl/ifetch_if.sv
// ifetch_if: fetch-stage bus bundle.
//   Instruction memory side : imem_req, imem_addr, imem_gnt, imem_rvalid, imem_rdata
//   Decode side             : ins, ins_pc, ins_valid, ins_ready, redirect, redirect_pc
// Modports:
//   master - the fetch unit (drives imem request and the instruction to decode)
//   slave  - the environment (memory + decoder/execute)
interface ifetch_if;

    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_gnt;
    logic        imem_rvalid;
    logic [31:0] imem_rdata;

    logic [31:0] ins;
    logic [31:0] ins_pc;
    logic        ins_valid;
    logic        ins_ready;
    logic        redirect;
    logic [31:0] redirect_pc;

    modport master (
        output imem_req, imem_addr, ins, ins_pc, ins_valid,
        input  imem_gnt, imem_rvalid, imem_rdata, ins_ready, redirect, redirect_pc
    );

    modport slave (
        input  imem_req, imem_addr, ins, ins_pc, ins_valid,
        output imem_gnt, imem_rvalid, imem_rdata, ins_ready, redirect, redirect_pc
    );

endinterface

// File: rtl/ifetch_timeout_cnt.sv
// ifetch_timeout_cnt: clear/enable cycle counter guarding the memory response wait.
//   clk, rst  - clock, asynchronous active-high reset
//   clr       - synchronous clear (takes priority over en)
//   en        - count one missed-response cycle
//   expired   - this enabled cycle is the LIMIT-th consecutive one
module ifetch_timeout_cnt #(
    parameter int unsigned LIMIT = 15
) (
    input  logic clk,
    input  logic rst,
    input  logic clr,
    input  logic en,
    output logic expired
);

    localparam int unsigned W = $clog2(LIMIT + 1);
    localparam logic [W-1:0] LAST = W'(LIMIT - 1);

    logic [W-1:0] cnt_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt_q <= '0;
        end else if (clr) begin
            cnt_q <= '0;
        end else if (en) begin
            cnt_q <= cnt_q + W'(1);
        end
    end

    // Flags the cycle whose increment would reach LIMIT, so the FSM can
    // leave on that same edge instead of one cycle late.
    assign expired = en && (cnt_q == LAST);

endmodule

// File: rtl/ifetch_unit.sv
// ifetch_unit: instruction fetch stage for the single-cycle RV32I core.
// Owns the PC, issues one request at a time to instruction memory and holds
// the returned word for decode until it is retired.
//   clk, rst     - clock, asynchronous active-high reset
//   bus          - ifetch_if.master (imem request/grant/rvalid + decode valid/ready)
//   fetch_fault  - sticky fault flag (memory timeout or misaligned redirect)
// Parameters:
//   RESET_PC     - first fetch address after reset
//   IMEM_TIMEOUT - WAIT cycles without imem_rvalid before fault (1..255)
// Build option:
//   IFETCH_ALIGN_CHECK_EN - when defined, a retired redirect to a non-word
//                           address faults; otherwise the target is aligned down.
module ifetch_unit
    import ifetch_pkg::*;
#(
    parameter logic [31:0] RESET_PC     = 32'h0000_0000,
    parameter int unsigned IMEM_TIMEOUT = 15
) (
    input  logic      clk,
    input  logic      rst,
    ifetch_if.master  bus,
    output logic      fetch_fault
);

    state_e      state_q;
    logic [31:0] pc_q;
    logic [31:0] ins_q;
    logic [31:0] ins_pc_q;

    logic cnt_clr;
    logic cnt_en;
    logic cnt_expired;

    assign cnt_clr = (state_q == REQ) && bus.imem_gnt;
    assign cnt_en  = (state_q == WAIT) && !bus.imem_rvalid;

    ifetch_timeout_cnt #(
        .LIMIT (IMEM_TIMEOUT)
    ) u_timeout (
        .clk     (clk),
        .rst     (rst),
        .clr     (cnt_clr),
        .en      (cnt_en),
        .expired (cnt_expired)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q  <= IDLE;
            pc_q     <= RESET_PC;
            ins_q    <= INS_NOP;
            ins_pc_q <= RESET_PC;
        end else begin
            case (state_q)
                IDLE: state_q <= REQ;

                REQ: begin
                    if (bus.imem_gnt) begin
                        state_q <= WAIT;
                    end
                end

                WAIT: begin
                    // A response on the timeout edge still wins.
                    if (bus.imem_rvalid) begin
                        ins_q    <= bus.imem_rdata;
                        ins_pc_q <= pc_q;
                        state_q  <= HOLD;
                    end else if (cnt_expired) begin
                        state_q <= FAULT;
                    end
                end

                HOLD: begin
                    if (bus.ins_ready) begin
                        if (bus.redirect) begin
`ifdef IFETCH_ALIGN_CHECK_EN
                            if (bus.redirect_pc[1:0] != 2'b00) begin
                                state_q <= FAULT;
                            end else begin
                                pc_q    <= bus.redirect_pc;
                                state_q <= REQ;
                            end
`else
                            pc_q    <= align_word(bus.redirect_pc);
                            state_q <= REQ;
`endif
                        end else begin
                            pc_q    <= pc_q + PC_INC;
                            state_q <= REQ;
                        end
                    end
                end

                FAULT: state_q <= FAULT;

                default: state_q <= IDLE;
            endcase
        end
    end

    assign bus.imem_req  = (state_q == REQ);
    assign bus.imem_addr = pc_q;
    assign bus.ins       = ins_q;
    assign bus.ins_pc    = ins_pc_q;
    assign bus.ins_valid = (state_q == HOLD);
    assign fetch_fault   = (state_q == FAULT);

endmodule

// File: tb/tb_ifetch_unit.sv
module tb_ifetch_unit;

    logic clk;
    logic rst;
    logic fetch_fault;
    int   n_chk;
    int   n_fail;

    ifetch_if bus ();

    ifetch_unit #(
        .RESET_PC     (32'h0000_0000),
        .IMEM_TIMEOUT (15)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .bus         (bus),
        .fetch_fault (fetch_fault)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Stimulus only: grant now, respond the next cycle (must start in REQ).
    task automatic fetch(input logic [31:0] data);
        bus.imem_gnt = 1'b1;
        tick();
        bus.imem_gnt    = 1'b0;
        bus.imem_rvalid = 1'b1;
        bus.imem_rdata  = data;
        tick();
        bus.imem_rvalid = 1'b0;
    endtask

    // Stimulus only: retire the held instruction (must be in HOLD).
    task automatic retire(input logic redir, input logic [31:0] target);
        bus.ins_ready   = 1'b1;
        bus.redirect    = redir;
        bus.redirect_pc = target;
        tick();
        bus.ins_ready   = 1'b0;
        bus.redirect    = 1'b0;
        bus.redirect_pc = 32'h0;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        bus.imem_gnt = 1'b0; bus.imem_rvalid = 1'b0; bus.imem_rdata = 32'h0;
        bus.ins_ready = 1'b0; bus.redirect = 1'b0; bus.redirect_pc = 32'h0;
        tick(); tick();
        n_chk++; if (bus.imem_req !== 1'b0) begin n_fail++; $display("FAIL rst_req got=%b exp=0", bus.imem_req); end
        n_chk++; if (bus.imem_addr !== 32'h0) begin n_fail++; $display("FAIL rst_addr got=%h exp=00000000", bus.imem_addr); end
        n_chk++; if (bus.ins !== 32'h0000_0013) begin n_fail++; $display("FAIL rst_ins got=%h exp=00000013", bus.ins); end
        n_chk++; if (bus.ins_pc !== 32'h0) begin n_fail++; $display("FAIL rst_ins_pc got=%h exp=00000000", bus.ins_pc); end
        n_chk++; if (bus.ins_valid !== 1'b0) begin n_fail++; $display("FAIL rst_valid got=%b exp=0", bus.ins_valid); end
        n_chk++; if (fetch_fault !== 1'b0) begin n_fail++; $display("FAIL rst_fault got=%b exp=0", fetch_fault); end
        rst = 1'b0;
        tick();
        n_chk++; if (bus.imem_req !== 1'b1) begin n_fail++; $display("FAIL first_req got=%b exp=1", bus.imem_req); end
        n_chk++; if (bus.imem_addr !== 32'h0) begin n_fail++; $display("FAIL first_addr got=%h exp=00000000", bus.imem_addr); end
    endtask

    task automatic test_basic();
        bus.imem_gnt = 1'b1;
        tick();
        bus.imem_gnt = 1'b0;
        n_chk++; if (bus.imem_req !== 1'b0) begin n_fail++; $display("FAIL wait_req got=%b exp=0", bus.imem_req); end
        n_chk++; if (bus.ins_valid !== 1'b0) begin n_fail++; $display("FAIL wait_valid got=%b exp=0", bus.ins_valid); end
        bus.imem_rvalid = 1'b1; bus.imem_rdata = 32'h0050_0093;
        tick();
        bus.imem_rvalid = 1'b0;
        n_chk++; if (bus.ins_valid !== 1'b1) begin n_fail++; $display("FAIL basic_valid got=%b exp=1", bus.ins_valid); end
        n_chk++; if (bus.ins !== 32'h0050_0093) begin n_fail++; $display("FAIL basic_ins got=%h exp=00500093", bus.ins); end
        n_chk++; if (bus.ins_pc !== 32'h0) begin n_fail++; $display("FAIL basic_ins_pc got=%h exp=00000000", bus.ins_pc); end
        n_chk++; if (bus.imem_req !== 1'b0) begin n_fail++; $display("FAIL hold_req got=%b exp=0", bus.imem_req); end
        retire(1'b0, 32'h0);
        n_chk++; if (bus.ins_valid !== 1'b0) begin n_fail++; $display("FAIL valid_fall got=%b exp=0", bus.ins_valid); end
        n_chk++; if (bus.imem_addr !== 32'h4) begin n_fail++; $display("FAIL basic_next_addr got=%h exp=00000004", bus.imem_addr); end
    endtask

    task automatic test_stall();
        fetch(32'h0010_0113);
        for (int i = 0; i < 5; i++) begin
            tick();
            n_chk++; if (bus.ins !== 32'h0010_0113 || bus.ins_pc !== 32'h4 || bus.ins_valid !== 1'b1 || bus.imem_req !== 1'b0) begin
                n_fail++;
                $display("FAIL stall_hold[%0d] got ins=%h pc=%h v=%b req=%b exp ins=00100113 pc=00000004 v=1 req=0",
                         i, bus.ins, bus.ins_pc, bus.ins_valid, bus.imem_req);
            end
        end
        retire(1'b0, 32'h0);
        n_chk++; if (bus.imem_addr !== 32'h8 || bus.imem_req !== 1'b1) begin n_fail++; $display("FAIL stall_next got addr=%h req=%b exp addr=00000008 req=1", bus.imem_addr, bus.imem_req); end
    endtask

    task automatic test_redirect();
        fetch(32'h0000_0063);
        // Redirect without ready is not a handshake.
        bus.redirect = 1'b1; bus.redirect_pc = 32'h0000_0300;
        tick();
        bus.redirect = 1'b0; bus.redirect_pc = 32'h0;
        n_chk++; if (bus.ins_valid !== 1'b1) begin n_fail++; $display("FAIL redir_noready got valid=%b exp=1", bus.ins_valid); end
        retire(1'b1, 32'h0000_0100);
        n_chk++; if (bus.imem_addr !== 32'h0000_0100) begin n_fail++; $display("FAIL redir_addr got=%h exp=00000100", bus.imem_addr); end
        bus.imem_gnt = 1'b1;
        tick();
        bus.imem_gnt = 1'b0;
        bus.redirect = 1'b1; bus.redirect_pc = 32'h0000_0200;
        tick();
        bus.redirect = 1'b0; bus.redirect_pc = 32'h0;
        bus.imem_rvalid = 1'b1; bus.imem_rdata = 32'h0000_0033;
        tick();
        bus.imem_rvalid = 1'b0;
        n_chk++; if (bus.ins_pc !== 32'h0000_0100) begin n_fail++; $display("FAIL redir_ins_pc got=%h exp=00000100", bus.ins_pc); end
        retire(1'b0, 32'h0);
        n_chk++; if (bus.imem_addr !== 32'h0000_0104) begin n_fail++; $display("FAIL redir_wait_ignored got=%h exp=00000104", bus.imem_addr); end
    endtask

    task automatic test_spurious();
        bus.imem_rvalid = 1'b1; bus.imem_rdata = 32'hDEAD_BEEF;
        tick();
        bus.imem_rvalid = 1'b0;
        n_chk++; if (bus.imem_req !== 1'b1 || bus.ins_valid !== 1'b0 || bus.ins !== 32'h0000_0033) begin
            n_fail++; $display("FAIL spur_req got req=%b v=%b ins=%h exp req=1 v=0 ins=00000033", bus.imem_req, bus.ins_valid, bus.ins);
        end
        fetch(32'h0020_8133);
        bus.imem_rvalid = 1'b1; bus.imem_rdata = 32'hDEAD_BEEF; bus.imem_gnt = 1'b1;
        tick();
        bus.imem_rvalid = 1'b0; bus.imem_gnt = 1'b0;
        n_chk++; if (bus.ins !== 32'h0020_8133 || bus.ins_valid !== 1'b1 || bus.imem_req !== 1'b0) begin
            n_fail++; $display("FAIL spur_hold got ins=%h v=%b req=%b exp ins=00208133 v=1 req=0", bus.ins, bus.ins_valid, bus.imem_req);
        end
        retire(1'b0, 32'h0);
        n_chk++; if (bus.imem_addr !== 32'h0000_0108) begin n_fail++; $display("FAIL spur_next got=%h exp=00000108", bus.imem_addr); end
    endtask

    task automatic test_wrap();
        fetch(32'h0000_0013);
        retire(1'b1, 32'hFFFF_FFFC);
        n_chk++; if (bus.imem_addr !== 32'hFFFF_FFFC) begin n_fail++; $display("FAIL wrap_top got=%h exp=fffffffc", bus.imem_addr); end
        fetch(32'h0000_0013);
        n_chk++; if (bus.ins_pc !== 32'hFFFF_FFFC) begin n_fail++; $display("FAIL wrap_ins_pc got=%h exp=fffffffc", bus.ins_pc); end
        retire(1'b0, 32'h0);
        n_chk++; if (bus.imem_addr !== 32'h0) begin n_fail++; $display("FAIL wrap_zero got=%h exp=00000000", bus.imem_addr); end
    endtask

    task automatic test_timeout();
        for (int i = 0; i < 10; i++) tick();
        n_chk++; if (bus.imem_req !== 1'b1 || bus.ins_valid !== 1'b0) begin n_fail++; $display("FAIL gnt_stall got req=%b v=%b exp req=1 v=0", bus.imem_req, bus.ins_valid); end
        bus.imem_gnt = 1'b1;
        tick();
        bus.imem_gnt = 1'b0;
        for (int i = 0; i < 14; i++) tick();
        n_chk++; if (fetch_fault !== 1'b0 || bus.imem_req !== 1'b0) begin n_fail++; $display("FAIL to_14 got fault=%b req=%b exp fault=0 req=0", fetch_fault, bus.imem_req); end
        // Response in the 15th WAIT cycle beats the timeout.
        bus.imem_rvalid = 1'b1; bus.imem_rdata = 32'h0000_1037;
        tick();
        bus.imem_rvalid = 1'b0;
        n_chk++; if (fetch_fault !== 1'b0 || bus.ins_valid !== 1'b1 || bus.ins !== 32'h0000_1037) begin
            n_fail++; $display("FAIL to_edge_win got fault=%b v=%b ins=%h exp fault=0 v=1 ins=00001037", fetch_fault, bus.ins_valid, bus.ins);
        end
        retire(1'b0, 32'h0);
        bus.imem_gnt = 1'b1;
        tick();
        bus.imem_gnt = 1'b0;
        for (int i = 0; i < 14; i++) tick();
        n_chk++; if (fetch_fault !== 1'b0) begin n_fail++; $display("FAIL to_pre got=%b exp=0", fetch_fault); end
        tick();
        n_chk++; if (fetch_fault !== 1'b1 || bus.ins_valid !== 1'b0 || bus.imem_req !== 1'b0) begin
            n_fail++; $display("FAIL to_fault got fault=%b v=%b req=%b exp fault=1 v=0 req=0", fetch_fault, bus.ins_valid, bus.imem_req);
        end
        bus.imem_rvalid = 1'b1; bus.imem_gnt = 1'b1; bus.ins_ready = 1'b1;
        tick(); tick(); tick();
        bus.imem_rvalid = 1'b0; bus.imem_gnt = 1'b0; bus.ins_ready = 1'b0;
        n_chk++; if (fetch_fault !== 1'b1 || bus.imem_req !== 1'b0) begin n_fail++; $display("FAIL to_sticky got fault=%b req=%b exp fault=1 req=0", fetch_fault, bus.imem_req); end
        rst = 1'b1;
        #1;
        n_chk++; if (fetch_fault !== 1'b0 || bus.imem_addr !== 32'h0) begin n_fail++; $display("FAIL to_rst got fault=%b addr=%h exp fault=0 addr=00000000", fetch_fault, bus.imem_addr); end
        tick();
        rst = 1'b0;
        tick();
        n_chk++; if (bus.imem_req !== 1'b1 || bus.imem_addr !== 32'h0) begin n_fail++; $display("FAIL to_restart got req=%b addr=%h exp req=1 addr=00000000", bus.imem_req, bus.imem_addr); end
    endtask

    task automatic test_reset_in_wait();
        fetch(32'h0000_0093);
        retire(1'b1, 32'h0000_0040);
        bus.imem_gnt = 1'b1;
        tick();
        bus.imem_gnt = 1'b0;
        rst = 1'b1;
        #1;
        n_chk++; if (bus.ins !== 32'h0000_0013 || bus.imem_addr !== 32'h0) begin n_fail++; $display("FAIL wrst_now got ins=%h addr=%h exp ins=00000013 addr=00000000", bus.ins, bus.imem_addr); end
        tick();
        rst = 1'b0;
        bus.imem_rvalid = 1'b1; bus.imem_rdata = 32'hCAFE_BABE;
        tick();
        tick();
        bus.imem_rvalid = 1'b0;
        n_chk++; if (bus.imem_req !== 1'b1 || bus.ins_valid !== 1'b0 || bus.ins !== 32'h0000_0013 || bus.imem_addr !== 32'h0) begin
            n_fail++; $display("FAIL wrst_discard got req=%b v=%b ins=%h addr=%h exp req=1 v=0 ins=00000013 addr=00000000",
                               bus.imem_req, bus.ins_valid, bus.ins, bus.imem_addr);
        end
    endtask

    task automatic test_align();
        fetch(32'h0000_0013);
        retire(1'b1, 32'h0000_0102);
`ifdef IFETCH_ALIGN_CHECK_EN
        n_chk++; if (fetch_fault !== 1'b1 || bus.ins_valid !== 1'b0 || bus.imem_req !== 1'b0 || bus.imem_addr !== 32'h0) begin
            n_fail++; $display("FAIL align_fault got fault=%b v=%b req=%b addr=%h exp fault=1 v=0 req=0 addr=00000000",
                               fetch_fault, bus.ins_valid, bus.imem_req, bus.imem_addr);
        end
`else
        n_chk++; if (fetch_fault !== 1'b0 || bus.imem_req !== 1'b1 || bus.imem_addr !== 32'h0000_0100) begin
            n_fail++; $display("FAIL align_down got fault=%b req=%b addr=%h exp fault=0 req=1 addr=00000100",
                               fetch_fault, bus.imem_req, bus.imem_addr);
        end
`endif
    endtask

    initial begin
        n_chk  = 0;
        n_fail = 0;
        test_reset();
        test_basic();
        test_stall();
        test_redirect();
        test_spurious();
        test_wrap();
        test_timeout();
        test_reset_in_wait();
        test_align();
        $display("TB_RESULT checks=%0d failures=%0d", n_chk, n_fail);
        $finish;
    end

endmodule
